// File: rtl/fpu_drv_pkg.sv
// Shared encodings for the divide/sqrt FPU driver.
package fpu_drv_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSend,
      StWaitZ,
      StAckZ,
      StHold
   } state_e;

   localparam logic OP_DIV  = 1'b0;
   localparam logic OP_SQRT = 1'b1;

   // Quiet NaN returned when a transaction is aborted.
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_drv_timer.sv
// Watchdog counter: cleared on demand, counts while enabled, flags the
// TIMEOUT-th enabled cycle so the FSM can abort on that edge.
module fpu_drv_timer #(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned TO_W    = 11
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TO_W-1:0] cnt_q;

   // Count enabled cycles; clear has priority over enable.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = en && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_op_driver.sv
// Host-to-FPU bridge: takes one div/sqrt command, runs the operand stb/ack
// handshakes, collects the result strobe and hands the result back.
module fpu_op_driver
   import fpu_drv_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned TO_W    = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic        fpu_process,
   output logic        fpu_a_stb,
   input  logic        fpu_a_ack,
   output logic        fpu_b_stb,
   input  logic        fpu_b_ack,
   input  logic [31:0] fpu_z,
   input  logic        fpu_z_stb,
   output logic        fpu_z_ack,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_err,
   output logic [15:0] txn_count
);

   state_e      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic        proc_q, proc_d;
   logic        a_stb_q, a_stb_d, b_stb_q, b_stb_d;
   logic        a_done_q, a_done_d, b_done_q, b_done_d;
   logic        z_ack_q, z_ack_d;
   logic [31:0] res_data_q, res_data_d;
   logic        res_err_q, res_err_d;
   logic [15:0] txn_q, txn_d;
   logic        tmr_clr, tmr_en, tmr_expired, abort;

   fpu_drv_timer #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         proc_q     <= OP_DIV;
         a_stb_q    <= 1'b0;
         b_stb_q    <= 1'b0;
         a_done_q   <= 1'b0;
         b_done_q   <= 1'b0;
         z_ack_q    <= 1'b0;
         res_data_q <= '0;
         res_err_q  <= 1'b0;
         txn_q      <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         proc_q     <= proc_d;
         a_stb_q    <= a_stb_d;
         b_stb_q    <= b_stb_d;
         a_done_q   <= a_done_d;
         b_done_q   <= b_done_d;
         z_ack_q    <= z_ack_d;
         res_data_q <= res_data_d;
         res_err_q  <= res_err_d;
         txn_q      <= txn_d;
      end
   end

   // Next-state: handshake sequencing, watchdog abort and result capture.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      proc_d     = proc_q;
      a_stb_d    = a_stb_q;
      b_stb_d    = b_stb_q;
      a_done_d   = a_done_q;
      b_done_d   = b_done_q;
      z_ack_d    = z_ack_q;
      res_data_d = res_data_q;
      res_err_d  = res_err_q;
      txn_d      = txn_q;
      tmr_clr    = 1'b0;
      tmr_en     = 1'b0;
      abort      = 1'b0;

      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               a_d      = cmd_a;
               b_d      = (cmd_op == OP_SQRT) ? 32'h0 : cmd_b;
               proc_d   = cmd_op;
               a_stb_d  = 1'b1;
               b_stb_d  = (cmd_op == OP_DIV);
               a_done_d = 1'b0;
               // sqrt has no B operand, so B counts as already delivered.
               b_done_d = (cmd_op == OP_SQRT);
               tmr_clr  = 1'b1;
               state_d  = StSend;
            end
         end
         StSend: begin
            tmr_en = 1'b1;
            if (a_stb_q && fpu_a_ack) begin
               a_stb_d  = 1'b0;
               a_done_d = 1'b1;
            end
            if (b_stb_q && fpu_b_ack) begin
               b_stb_d  = 1'b0;
               b_done_d = 1'b1;
            end
            if (a_done_q && b_done_q) begin
               // Fresh watchdog budget for the result wait.
               tmr_clr = 1'b1;
               state_d = StWaitZ;
            end else if (tmr_expired) begin
               abort = 1'b1;
            end
         end
         StWaitZ: begin
            tmr_en = 1'b1;
            // A result arriving on the expiry edge takes priority.
            if (fpu_z_stb) begin
               res_data_d = fpu_z;
               res_err_d  = 1'b0;
               z_ack_d    = 1'b1;
               state_d    = StAckZ;
            end else if (tmr_expired) begin
               abort = 1'b1;
            end
         end
         StAckZ: begin
            z_ack_d = 1'b0;
            txn_d   = txn_q + 16'd1;
            state_d = StHold;
         end
         StHold: begin
            if (res_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (abort) begin
         a_stb_d    = 1'b0;
         b_stb_d    = 1'b0;
         res_data_d = QNAN;
         res_err_d  = 1'b1;
         txn_d      = txn_q + 16'd1;
         state_d    = StHold;
      end
   end

   assign cmd_ready   = (state_q == StIdle);
   assign res_valid   = (state_q == StHold);
   assign fpu_a       = a_q;
   assign fpu_b       = b_q;
   assign fpu_process = proc_q;
   assign fpu_a_stb   = a_stb_q;
   assign fpu_b_stb   = b_stb_q;
   assign fpu_z_ack   = z_ack_q;
   assign res_data    = res_data_q;
   assign res_err     = res_err_q;
   assign txn_count   = txn_q;

endmodule

// File: tb/tb_fpu_op_driver.sv
// Bench for fpu_op_driver: behavioural FPU responder with programmable ack
// delays and latency, a host stimulus driver and a scoreboard monitor.
module tb_fpu_op_driver;

   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
   logic [31:0] cmd_a = '0, cmd_b = '0;
   logic [31:0] fpu_a, fpu_b, fpu_z;
   logic        fpu_process, fpu_a_stb, fpu_a_ack, fpu_b_stb, fpu_b_ack;
   logic        fpu_z_stb, fpu_z_ack;
   logic        res_valid, res_ready, res_err;
   logic [31:0] res_data;
   logic [15:0] txn_count;

   fpu_op_driver #(
      .TIMEOUT (TMO),
      .TO_W    (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .fpu_a       (fpu_a),
      .fpu_b       (fpu_b),
      .fpu_process (fpu_process),
      .fpu_a_stb   (fpu_a_stb),
      .fpu_a_ack   (fpu_a_ack),
      .fpu_b_stb   (fpu_b_stb),
      .fpu_b_ack   (fpu_b_ack),
      .fpu_z       (fpu_z),
      .fpu_z_stb   (fpu_z_stb),
      .fpu_z_ack   (fpu_z_ack),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_err     (res_err),
      .txn_count   (txn_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Exact IEEE-754 single cases: op (0 div, 1 sqrt), A, B, correct result.
   logic        tbl_op [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [31:0] tbl_a  [10] = '{32'h40C00000, 32'h3F800000, 32'h41100000, 32'h3F800000,
                                32'hC1000000, 32'h40800000, 32'h41800000, 32'h3F800000,
                                32'h3E800000, 32'h41100000};
   logic [31:0] tbl_b  [10] = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h40800000,
                                32'h40000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
   logic [31:0] tbl_z  [10] = '{32'h40400000, 32'h3F000000, 32'h40400000, 32'h3E800000,
                                32'hC0800000, 32'h40000000, 32'h40800000, 32'h3F800000,
                                32'h3F000000, 32'h40400000};

   // FPU behaviour as seen on its own pins; unknown operands give a marker value.
   function automatic logic [31:0] fpu_eval(input logic p, input logic [31:0] a,
                                            input logic [31:0] b);
      for (int i = 0; i < 10; i++) begin
         if (tbl_op[i] == p && tbl_a[i] == a && (p ? (b == 32'h0) : (b == tbl_b[i])))
            return tbl_z[i];
      end
      return 32'hDEADBEEF;
   endfunction

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic [15:0] cnt;
   } exp_t;
   exp_t        sb[$];
   logic [15:0] exp_txn = '0;

   // Responder configuration (changed only while the FPU side is idle).
   int a_delay = 0, b_delay = 0, z_lat = 0;
   bit z_never = 0;
   int in_done_cyc = 0;

   // FPU responder plus operand-strobe stability checks, all on the falling edge.
   initial begin
      bit          in_busy, z_arm, z_drop, prev_rst;
      int          a_hi, b_hi, z_cnt;
      logic [31:0] cap_a, cap_b, prev_a, prev_b;
      logic        cap_p, prev_p, prev_a_stb, prev_a_ack, prev_b_stb, prev_b_ack, prev_z_ack;
      in_busy = 0; z_arm = 0; z_drop = 0; prev_rst = 1;
      a_hi = 0; b_hi = 0; z_cnt = 0;
      cap_a = '0; cap_b = '0; cap_p = 0; prev_a = '0; prev_b = '0; prev_p = 0;
      prev_a_stb = 0; prev_a_ack = 0; prev_b_stb = 0; prev_b_ack = 0; prev_z_ack = 0;
      fpu_a_ack = 0; fpu_b_ack = 0; fpu_z_stb = 0; fpu_z = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_busy = 0; z_arm = 0; z_drop = 0; prev_rst = 1;
            fpu_a_ack = 0; fpu_b_ack = 0; fpu_z_stb = 0;
         end else begin
            if (!prev_rst) begin
               if (prev_a_stb && !prev_a_ack) begin
                  check("a_stb_held", {fpu_a_stb, fpu_process}, {1'b1, prev_p});
                  check("fpu_a_stable", fpu_a, prev_a);
               end
               if (prev_b_stb && !prev_b_ack) begin
                  check("b_stb_held", {fpu_b_stb, fpu_process}, {1'b1, prev_p});
                  check("fpu_b_stable", fpu_b, prev_b);
               end
            end
            if (fpu_z_ack) check("z_ack_single_with_stb", {fpu_z_stb, prev_z_ack}, 2'b10);
            if (z_drop) begin
               fpu_z_stb = 0;
               z_drop    = 0;
            end
            if (fpu_a_stb && !in_busy) begin
               in_busy = 1; a_hi = 0; b_hi = 0;
               cap_a = fpu_a; cap_b = fpu_b; cap_p = fpu_process;
            end
            if (fpu_a_stb) a_hi++;
            if (fpu_b_stb) b_hi++;
            fpu_a_ack = fpu_a_stb && (a_hi == a_delay + 1);
            fpu_b_ack = fpu_b_stb && (b_hi == b_delay + 1);
            if (in_busy && !fpu_a_stb && !fpu_b_stb) begin
               in_busy = 0;
               check("a_stb_cycles", a_hi, a_delay + 1);
               check("b_stb_cycles", b_hi, cap_p ? 0 : b_delay + 1);
               in_done_cyc = cyc;
               z_arm = !z_never;
               z_cnt = z_lat;
            end
            if (z_arm) begin
               if (z_cnt == 0) begin
                  fpu_z_stb = 1;
                  fpu_z     = fpu_eval(cap_p, cap_a, cap_b);
                  z_arm     = 0;
               end else begin
                  z_cnt--;
               end
            end
            if (fpu_z_stb && fpu_z_ack) z_drop = 1;
            prev_a_stb = fpu_a_stb; prev_a_ack = fpu_a_ack; prev_a = fpu_a;
            prev_b_stb = fpu_b_stb; prev_b_ack = fpu_b_ack; prev_b = fpu_b;
            prev_p = fpu_process; prev_z_ack = fpu_z_ack; prev_rst = 0;
         end
      end
   end

   // Host result side: drives res_ready with backpressure and scores results.
   int bp_hold   = -1;
   int valid_cyc = 0;
   initial begin
      int          hold_left;
      bit          m_prev_valid, m_prev_cons, m_prev_err;
      logic [31:0] m_prev_data;
      exp_t        e;
      hold_left = 0; m_prev_valid = 0; m_prev_cons = 0; m_prev_err = 0; m_prev_data = '0;
      res_ready = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            res_ready = 0;
            m_prev_valid = 0;
         end else begin
            if (res_valid) begin
               if (!m_prev_valid) valid_cyc = cyc;
               check("cmd_ready_low_in_hold", cmd_ready, 0);
               if (m_prev_valid && !m_prev_cons) begin
                  check("res_data_held", res_data, m_prev_data);
                  check("res_err_held", res_err, m_prev_err);
               end
               if (hold_left > 0) begin
                  res_ready = 0;
                  hold_left--;
               end else begin
                  res_ready = 1;
               end
               if (res_ready) begin
                  if (sb.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_result: got %h, none expected", res_data);
                  end else begin
                     e = sb.pop_front();
                     check("res_data", res_data, e.data);
                     check("res_err", res_err, e.err);
                     check("txn_count", txn_count, e.cnt);
                  end
               end
            end else begin
               res_ready = 1'($urandom_range(0, 1));
               hold_left = (bp_hold < 0) ? $urandom_range(0, 3) : bp_hold;
            end
            m_prev_valid = res_valid;
            m_prev_cons  = res_valid && res_ready;
            m_prev_data  = res_data;
            m_prev_err   = res_err;
         end
      end
   end

   // Wait for the driver to be idle, then offer one command from the table.
   task automatic issue(input int idx, input int ad, input int bd, input int zl, input bit zn);
      int guard = 0;
      @(negedge clk);
      #1;
      while (!cmd_ready && guard < 500) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!cmd_ready) begin
         total++;
         bad++;
         $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
         return;
      end
      a_delay = ad; b_delay = bd; z_lat = zl; z_never = zn;
      cmd_op    = tbl_op[idx];
      cmd_a     = tbl_a[idx];
      cmd_b     = tbl_op[idx] ? $urandom : tbl_b[idx];
      cmd_valid = 1;
      exp_txn   = exp_txn + 16'd1;
      sb.push_back('{data: zn ? 32'h7FC00000 : tbl_z[idx], err: zn, cnt: exp_txn});
      @(posedge clk);
      #1;
      cmd_valid = 0;
   endtask

   task automatic drain();
      int guard = 0;
      do begin
         @(negedge clk);
         #1;
         guard++;
      end while (!(sb.size() == 0 && !res_valid && cmd_ready) && guard < 2000);
      if (guard >= 2000) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int guard;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_strobes", {fpu_a_stb, fpu_b_stb, fpu_z_ack}, 3'b000);
      check("rst_process", fpu_process, 0);
      check("rst_fpu_a", fpu_a, 0);
      check("rst_fpu_b", fpu_b, 0);
      check("rst_res", {res_valid, res_err}, 2'b00);
      check("rst_res_data", res_data, 0);
      check("rst_txn_count", txn_count, 0);
      rst = 0;

      // Directed: div 6/2, sqrt 4, skewed acks, simultaneous acks.
      issue(0, 0, 0, 3, 0);
      issue(5, 0, 0, 2, 0);
      issue(2, 0, 3, 1, 0);
      issue(3, 2, 2, 4, 0);
      drain();

      // Result never arrives: abort after TMO cycles in WAIT_Z.
      issue(1, 0, 0, 0, 1);
      guard = 0;
      do begin
         @(negedge clk);
         #1;
         guard++;
      end while (!res_valid && guard < 200);
      check("timeout_res_valid", res_valid, 1);
      check("timeout_strobes", {fpu_a_stb, fpu_b_stb, fpu_z_ack}, 3'b000);
      check("timeout_wait_cycles", valid_cyc - in_done_cyc, TMO + 1);
      drain();

      // Host backpressure: result held for 5 cycles, next command waits.
      bp_hold = 5;
      issue(6, 1, 0, 2, 0);
      issue(7, 0, 0, 1, 0);
      drain();
      bp_hold = -1;

      // Reset while operand A is still being strobed.
      issue(4, 10, 10, 0, 0);
      repeat (3) @(negedge clk);
      #2;
      check("pre_reset_a_stb", fpu_a_stb, 1);
      rst = 1;
      @(negedge clk);
      #1;
      check("midrst_strobes", {fpu_a_stb, fpu_b_stb, fpu_z_ack}, 3'b000);
      check("midrst_cmd_ready", cmd_ready, 1);
      check("midrst_res_valid", res_valid, 0);
      check("midrst_txn_count", txn_count, 0);
      sb.delete();
      exp_txn = '0;
      rst = 0;

      // Randomised traffic.
      for (int i = 0; i < 30; i++) begin
         issue($urandom_range(0, 9), $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 6), ($urandom_range(0, 7) == 0));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
